// File: rtl/ground_pkg.sv
// ---------------------------------------------------------------------------
// ground_pkg
// Purpose : shared constants for the ground scroller and the ground tile
//           renderers, so both sides agree on tile geometry, screen width,
//           ground row and palette from one source.
// Contents: tile geometry, screen constants, 12-bit RGB colours and the
//           run-state type used by the scroller.
// ---------------------------------------------------------------------------
package ground_pkg;

    localparam int TILE_W    = 128;
    localparam int TILE_LOG2 = $clog2(TILE_W);
    localparam int SCREEN_W  = 640;
    localparam int GROUND_Y0 = 385;

    localparam logic [11:0] GRASS = 12'h0a0;
    localparam logic [11:0] DIRT  = 12'h742;
    localparam logic [11:0] STONE = 12'hda6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } run_state_t;

endpackage

// File: rtl/ground_scroller_speed_ramp.sv
// ---------------------------------------------------------------------------
// speed_ramp
// Purpose : holds the scroll speed and the frame counter that ramps it up.
//           Every RAMP_FRAMES steps the speed goes up by one, saturating at
//           MAX_SPEED; once saturated the counter keeps cycling harmlessly.
// Ports   : i_clk    - pixel clock
//           i_rst_n  - asynchronous active-low reset
//           i_load   - reload INIT_SPEED and clear the ramp counter
//           i_step   - one RUN frame elapsed (ignored while i_load is high)
//           o_speed  - current speed in pixels per frame
// ---------------------------------------------------------------------------
module speed_ramp
#(
    parameter int INIT_SPEED  = 2,
    parameter int MAX_SPEED   = 8,
    parameter int RAMP_FRAMES = 300,
    parameter int SPEED_W     = 4
)
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic               i_step,
    output logic [SPEED_W-1:0] o_speed
);
    import ground_pkg::*;

    localparam int                 CNT_W      = $clog2(RAMP_FRAMES + 1);
    localparam logic [CNT_W-1:0]   RAMP_LAST  = CNT_W'(RAMP_FRAMES - 1);
    localparam logic [SPEED_W-1:0] SPEED_INIT = SPEED_W'(INIT_SPEED);
    localparam logic [SPEED_W-1:0] SPEED_MAX  = SPEED_W'(MAX_SPEED);

    logic [CNT_W-1:0]   r_rampCount;
    logic [SPEED_W-1:0] r_speed;

    // Ramp counter and speed register. The counter wraps on its last value
    // and that same step bumps the speed, so the speed rises once every
    // RAMP_FRAMES steps. A load restarts the ramp from the initial speed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rampCount <= '0;
            r_speed     <= SPEED_INIT;
        end else if (i_load) begin
            r_rampCount <= '0;
            r_speed     <= SPEED_INIT;
        end else if (i_step) begin
            if (r_rampCount == RAMP_LAST) begin
                r_rampCount <= '0;
                if (r_speed < SPEED_MAX) begin
                    r_speed <= r_speed + 1'b1;
                end
            end else begin
                r_rampCount <= r_rampCount + 1'b1;
            end
        end
    end

    assign o_speed = r_speed;

endmodule

// File: rtl/ground_scroller.sv
// ---------------------------------------------------------------------------
// ground_scroller
// Purpose : upstream controller for the ground tile renderers. Keeps the
//           horizontal scroll phase of the repeating ground tile, steps it
//           once per frame at a ramping speed, runs the IDLE/RUN/HALT flow
//           of a run and counts the distance score.
// Ports   : i_clk          - pixel clock
//           i_rst_n        - asynchronous active-low reset
//           i_frame_tick   - one-cycle pulse at start of vertical blank
//           i_start        - start request, sampled only on a tick
//           i_collide      - obstacle hit, sampled only on a tick
//           o_tile_right   - packed 11-bit right-edge x of each tile copy
//           o_speed        - current pixels per frame
//           o_distance     - RUN frames so far, saturating
//           o_running      - high in RUN
//           o_halted       - high in HALT
// All state changes only on a tick edge, so the outputs are steady for the
// whole active video of a frame and the tiles never tear.
// ---------------------------------------------------------------------------
module ground_scroller
#(
    parameter int TILE_W      = ground_pkg::TILE_W,
    parameter int NUM_TILES   = 6,
    parameter int INIT_SPEED  = 2,
    parameter int MAX_SPEED   = 8,
    parameter int RAMP_FRAMES = 300,
    parameter int SPEED_W     = 4
)
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_frame_tick,
    input  logic                    i_start,
    input  logic                    i_collide,
    output logic [11*NUM_TILES-1:0] o_tile_right,
    output logic [SPEED_W-1:0]      o_speed,
    output logic [15:0]             o_distance,
    output logic                    o_running,
    output logic                    o_halted
);
    import ground_pkg::*;

    localparam int                 PHASE_W    = $clog2(TILE_W);
    localparam logic [PHASE_W-1:0] PHASE_INIT = PHASE_W'(TILE_W - 1);
    localparam logic [15:0]        DIST_MAX   = 16'hFFFF;

    run_state_t         r_state;
    logic [PHASE_W-1:0] r_phase;
    logic [15:0]        r_distance;
    logic [SPEED_W-1:0] w_speed;
    logic [PHASE_W-1:0] w_phaseNext;
    logic               w_load;
    logic               w_step;

    // Speed reloads whenever a run is armed (IDLE->RUN) or disarmed
    // (HALT->IDLE); it ramps on every RUN tick that is not a collision.
    assign w_load = i_frame_tick && i_start &&
                    ((r_state == ST_IDLE) || (r_state == ST_HALT));
    assign w_step = i_frame_tick && !i_collide && (r_state == ST_RUN);

    // Tile width is a power of two, so keeping only the phase-width bits of
    // the difference is the modulo; speed < TILE_W keeps one wrap enough.
    assign w_phaseNext = r_phase - PHASE_W'(w_speed);

    speed_ramp #(
        .INIT_SPEED  (INIT_SPEED),
        .MAX_SPEED   (MAX_SPEED),
        .RAMP_FRAMES (RAMP_FRAMES),
        .SPEED_W     (SPEED_W)
    ) u_speedRamp (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_load),
        .i_step  (w_step),
        .o_speed (w_speed)
    );

    // Run-state flow, scroll phase and distance. Collision wins over start
    // in RUN and freezes everything. Leaving HALT only returns to IDLE, so a
    // held start button needs a second tick to begin a new run.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_phase    <= PHASE_INIT;
            r_distance <= '0;
        end else if (i_frame_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state    <= ST_RUN;
                        r_phase    <= PHASE_INIT;
                        r_distance <= '0;
                    end
                end
                ST_RUN: begin
                    if (i_collide) begin
                        r_state <= ST_HALT;
                    end else begin
                        r_phase <= w_phaseNext;
                        if (r_distance != DIST_MAX) begin
                            r_distance <= r_distance + 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if (i_start) begin
                        r_state    <= ST_IDLE;
                        r_phase    <= PHASE_INIT;
                        r_distance <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Right edge of tile copy k is the phase plus k whole tiles. Tile 0 can
    // sit partly left of the screen; the renderer clips that side.
    always_comb begin
        o_tile_right = '0;
        for (int k = 0; k < NUM_TILES; k++) begin
            o_tile_right[k*11 +: 11] = 11'(r_phase) + 11'(k * TILE_W);
        end
    end

    assign o_speed    = w_speed;
    assign o_distance = r_distance;
    assign o_running  = (r_state == ST_RUN);
    assign o_halted   = (r_state == ST_HALT);

endmodule
